mr_feeder: RTL and testbench

- Issuing and collecting end of the modular-reduction pipeline interface.
- Accepts operand pairs (a, b) from the NTT datapath with ready/valid, forms U = a*b, and drives the reducer's U/valid_in.
- Captures the reducer's Z/valid_out into an in-order result FIFO, then presents results downstream with ready/valid.
- The reducer has no backpressure, so this block does credit-based admission so no returning result is ever lost.

---
 rtl/mr_pkg.sv | 16 +
 rtl/mr_feeder_if.sv | 31 +++
 rtl/mr_feeder_fifo.sv | 66 ++++++
 rtl/mr_feeder.sv | 124 ++++++++++++
 tb/tb_mr_feeder.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mr_pkg.sv
// Shared constants and types for the modular-reduction feeder.
package mr_pkg;

    localparam int unsigned M_DEFAULT       = 12289;
    localparam int unsigned M_WIDTH_DEFAULT = $clog2(M_DEFAULT);
    localparam int unsigned U_WIDTH_DEFAULT = 31;

    typedef logic [M_WIDTH_DEFAULT-1:0] coef_t;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/mr_feeder_if.sv
// Operand, reducer and result handshake bundle; master is the feeder side.
interface mr_feeder_if
    import mr_pkg::*;
#(
    parameter int unsigned M_WIDTH = M_WIDTH_DEFAULT,
    parameter int unsigned U_WIDTH = U_WIDTH_DEFAULT
) ();

    logic [M_WIDTH-1:0] in_a;
    logic [M_WIDTH-1:0] in_b;
    logic               in_valid;
    logic               in_ready;
    logic [U_WIDTH-1:0] u_out;
    logic               u_valid;
    logic [M_WIDTH-1:0] z_in;
    logic               z_valid;
    logic [M_WIDTH-1:0] out_z;
    logic               out_valid;
    logic               out_ready;

    modport master (
        input  in_a, in_b, in_valid, z_in, z_valid, out_ready,
        output in_ready, u_out, u_valid, out_z, out_valid
    );

    modport slave (
        output in_a, in_b, in_valid, z_in, z_valid, out_ready,
        input  in_ready, u_out, u_valid, out_z, out_valid
    );

endinterface

// File: rtl/mr_feeder_fifo.sv
// In-order result FIFO with first-word fall-through head and count output.
// A write arriving while full is dropped and flagged on drop_o.
module mr_feeder_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 14
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wr_en_i,
    input  logic [WIDTH-1:0]        wr_data_i,
    input  logic                    rd_en_i,
    output logic [WIDTH-1:0]        rd_data_o,
    output logic [$clog2(DEPTH):0]  count_o,
    output logic                    drop_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PtrW:0]    count_q, count_d;
    logic             full, empty, do_wr, do_rd;

    assign full   = (count_q == (PtrW+1)'(DEPTH));
    assign empty  = (count_q == '0);
    assign do_wr  = wr_en_i && !full;
    assign do_rd  = rd_en_i && !empty;
    assign drop_o = wr_en_i && full;

    assign rd_data_o = mem_q[rd_ptr_q];
    assign count_o   = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_wr) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_rd) rd_ptr_d = rd_ptr_q + 1'b1;
        unique case ({do_wr, do_rd})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Storage is cleared on reset so the head reads zero out of reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (do_wr) begin
                mem_q[wr_ptr_q] <= wr_data_i;
            end
        end
    end

endmodule

// File: rtl/mr_feeder.sv
// Issue/collect front end of the modular reducer with credit-based admission.
// Define MR_FEEDER_RANGE_CHECK_EN to add the sticky range_err output.
module mr_feeder
    import mr_pkg::*;
#(
    parameter int unsigned U_WIDTH = U_WIDTH_DEFAULT,
    parameter int unsigned M       = M_DEFAULT,
    parameter int unsigned M_WIDTH = $clog2(M),
    parameter int unsigned DEPTH   = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    mr_feeder_if.master bus,
    input  logic        flush_req,
    output logic        flush_done,
    output logic        ovf_err
`ifdef MR_FEEDER_RANGE_CHECK_EN
    ,
    output logic        range_err
`endif
);

    localparam int unsigned OccW = $clog2(DEPTH) + 1;

    if (2 * M_WIDTH > U_WIDTH) begin : g_chk_uw
        $error("U_WIDTH cannot hold the full operand product");
    end
    if (DEPTH < 2 || DEPTH > 64 || (DEPTH & (DEPTH - 1)) != 0) begin : g_chk_depth
        $error("DEPTH must be a power of two in 2..64");
    end
    if (M >= (1 << M_WIDTH)) begin : g_chk_m
        $error("M does not fit in M_WIDTH bits");
    end

    state_e              state_q, state_d;
    logic [OccW-1:0]     occ_q, occ_d;
    logic [U_WIDTH-1:0]  u_out_q, u_out_d;
    logic                u_valid_q;
    logic                ovf_err_q;
    logic                accept, pop, fifo_drop;
    logic [OccW-1:0]     fifo_count;
    logic [2*M_WIDTH-1:0] prod;

    // Occupancy counts in-flight plus stored results, so admission can never
    // oversubscribe the FIFO even though the reducer cannot be stalled.
    assign bus.in_ready = rst_n && (state_q == RUN) && (occ_q < OccW'(DEPTH));
    assign accept       = bus.in_valid && bus.in_ready;
    assign pop          = bus.out_valid && bus.out_ready;

    assign prod    = {{M_WIDTH{1'b0}}, bus.in_a} * {{M_WIDTH{1'b0}}, bus.in_b};
    assign u_out_d = accept ? U_WIDTH'(prod) : u_out_q;

    assign bus.u_out   = u_out_q;
    assign bus.u_valid = u_valid_q;
    assign flush_done  = (state_q == DONE);
    assign ovf_err     = ovf_err_q;

    always_comb begin
        occ_d = occ_q;
        unique case ({accept, pop})
            2'b10:   occ_d = occ_q + 1'b1;
            2'b01:   occ_d = occ_q - 1'b1;
            default: occ_d = occ_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN:     if (flush_req) state_d = DRAIN;
            DRAIN:   if (occ_q == '0) state_d = DONE;
            DONE:    state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= RUN;
            occ_q     <= '0;
            u_out_q   <= '0;
            u_valid_q <= 1'b0;
            ovf_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            occ_q     <= occ_d;
            u_out_q   <= u_out_d;
            u_valid_q <= accept;
            if (fifo_drop) ovf_err_q <= 1'b1;
        end
    end

    mr_feeder_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (M_WIDTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en_i   (bus.z_valid),
        .wr_data_i (bus.z_in),
        .rd_en_i   (pop),
        .rd_data_o (bus.out_z),
        .count_o   (fifo_count),
        .drop_o    (fifo_drop)
    );

    assign bus.out_valid = (fifo_count != '0);

`ifdef MR_FEEDER_RANGE_CHECK_EN
    localparam logic [M_WIDTH:0] MVal = (M_WIDTH+1)'(M);
    logic range_err_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            range_err_q <= 1'b0;
        end else if (bus.z_valid && ({1'b0, bus.z_in} >= MVal)) begin
            range_err_q <= 1'b1;
        end
    end

    assign range_err = range_err_q;
`endif

endmodule

// File: tb/tb_mr_feeder.sv
// Directed closed-loop bench: mr_feeder plus a 3-cycle behavioural reducer.
module tb_mr_feeder;
    import mr_pkg::*;

    logic  clk;
    logic  rst_n;
    logic  flush_req;
    logic  flush_done;
    logic  ovf_err;
`ifdef MR_FEEDER_RANGE_CHECK_EN
    logic  range_err;
`endif
    logic  z_force;
    coef_t z_force_val;
    int    total;
    int    bad;

    mr_feeder_if #(.M_WIDTH(M_WIDTH_DEFAULT), .U_WIDTH(U_WIDTH_DEFAULT)) bus ();

    mr_feeder dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .flush_req  (flush_req),
        .flush_done (flush_done),
        .ovf_err    (ovf_err)
`ifdef MR_FEEDER_RANGE_CHECK_EN
        ,
        .range_err  (range_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reducer stand-in: Z = U mod M, three register stages, shares rst_n.
    logic [2:0] rv;
    coef_t      rz0, rz1, rz2;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rv  <= '0;
            rz0 <= '0;
            rz1 <= '0;
            rz2 <= '0;
        end else begin
            rv  <= {rv[1:0], bus.u_valid};
            rz0 <= coef_t'(32'(bus.u_out) % M_DEFAULT);
            rz1 <= rz0;
            rz2 <= rz1;
        end
    end
    assign bus.z_valid = z_force ? 1'b1 : rv[2];
    assign bus.z_in    = z_force ? z_force_val : rz2;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One pair with out_ready high: product after one edge, result after five.
    task automatic single(input int a, input int b, input int exp_u, input int exp_z);
        bus.in_a     = 14'(a);
        bus.in_b     = 14'(b);
        bus.in_valid = 1'b1;
        chk("single_ready", 32'(bus.in_ready), 1);
        tick();
        bus.in_valid = 1'b0;
        chk("single_uvalid", 32'(bus.u_valid), 1);
        chk("single_uout", 32'(bus.u_out), 32'(exp_u));
        tick();
        chk("single_uvalid_off", 32'(bus.u_valid), 0);
        tick();
        tick();
        chk("single_early", 32'(bus.out_valid), 0);
        tick();
        chk("single_ovalid", 32'(bus.out_valid), 1);
        chk("single_outz", 32'(bus.out_z), 32'(exp_z));
        tick();
        chk("single_popped", 32'(bus.out_valid), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int pops;
        int fd_cnt;
        int fd_at;
        int pop4_at;
        int seen;

        total         = 0;
        bad           = 0;
        rst_n         = 1'b0;
        flush_req     = 1'b0;
        z_force       = 1'b0;
        z_force_val   = '0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;

        tick();
        tick();
        chk("rst_in_ready", 32'(bus.in_ready), 0);
        chk("rst_u_out", 32'(bus.u_out), 0);
        chk("rst_u_valid", 32'(bus.u_valid), 0);
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_out_z", 32'(bus.out_z), 0);
        chk("rst_flush_done", 32'(flush_done), 0);
        chk("rst_ovf_err", 32'(ovf_err), 0);
        rst_n = 1'b1;
        tick();

        single(3, 5, 15, 15);
        // 12288 is -1 mod 12289, so the square reduces to 1.
        single(12288, 12288, 150994944, 1);

        // Backpressure: only DEPTH pairs are admitted while out_ready is low.
        bus.out_ready = 1'b0;
        acc = 0;
        for (int i = 1; i <= 10; i++) begin
            bus.in_a     = 14'(i);
            bus.in_b     = 14'd2;
            bus.in_valid = 1'b1;
            if (bus.in_ready) acc++;
            tick();
        end
        bus.in_valid = 1'b0;
        chk("bp_accepted", 32'(acc), 8);
        chk("bp_ready_low", 32'(bus.in_ready), 0);
        for (int i = 0; i < 4; i++) tick();
        chk("bp_head_valid", 32'(bus.out_valid), 1);
        chk("bp_head_held", 32'(bus.out_z), 2);
        chk("bp_ready_still_low", 32'(bus.in_ready), 0);
        bus.out_ready = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            chk("bp_order_valid", 32'(bus.out_valid), 1);
            chk("bp_order_z", 32'(bus.out_z), 32'(2 * k));
            tick();
        end
        chk("bp_empty", 32'(bus.out_valid), 0);
        chk("bp_ready_back", 32'(bus.in_ready), 1);
        chk("bp_no_ovf", 32'(ovf_err), 0);

        // Flush with four pairs in flight; a pair offered during drain is refused.
        for (int i = 0; i < 4; i++) begin
            bus.in_a     = 14'(100 + i);
            bus.in_b     = 14'd1;
            bus.in_valid = 1'b1;
            tick();
        end
        bus.in_valid = 1'b0;
        flush_req    = 1'b1;
        tick();
        flush_req = 1'b0;
        chk("fl_ready_low", 32'(bus.in_ready), 0);
        bus.in_a     = 14'd7;
        bus.in_b     = 14'd1;
        bus.in_valid = 1'b1;
        pops    = 0;
        fd_cnt  = 0;
        fd_at   = -1;
        pop4_at = -1;
        for (int s = 0; s < 30; s++) begin
            if (bus.out_valid && bus.out_ready) begin
                chk("fl_order", 32'(bus.out_z), 32'(100 + pops));
                pops++;
                if (pops == 4) pop4_at = s;
            end
            if (flush_done) begin
                fd_cnt++;
                fd_at        = s;
                bus.in_valid = 1'b0;
            end
            tick();
        end
        bus.in_valid = 1'b0;
        chk("fl_pops", 32'(pops), 4);
        chk("fl_done_pulses", 32'(fd_cnt), 1);
        // Pop at edge E empties occ; DRAIN sees it at E+1, DONE shows after E+1.
        chk("fl_done_timing", 32'(fd_at - pop4_at), 2);
        chk("fl_run_resumed", 32'(bus.in_ready), 1);

        // Overflow: FIFO full by credits, then an extra return is forced in.
        bus.out_ready = 1'b0;
        bus.in_a      = 14'd1;
        bus.in_b      = 14'd1;
        bus.in_valid  = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        bus.in_valid = 1'b0;
        chk("ovf_ready_low", 32'(bus.in_ready), 0);
        for (int i = 0; i < 6; i++) tick();
        chk("ovf_pre", 32'(ovf_err), 0);
        z_force     = 1'b1;
        z_force_val = 14'd55;
        tick();
        z_force = 1'b0;
        chk("ovf_set", 32'(ovf_err), 1);
        chk("ovf_head_kept", 32'(bus.out_z), 1);
`ifdef MR_FEEDER_RANGE_CHECK_EN
        chk("range_clear", 32'(range_err), 0);
        z_force     = 1'b1;
        z_force_val = 14'd12289;
        tick();
        z_force = 1'b0;
        chk("range_set", 32'(range_err), 1);
`endif
        tick();
        chk("ovf_sticky", 32'(ovf_err), 1);
        bus.out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            chk("ovf_drain_valid", 32'(bus.out_valid), 1);
            chk("ovf_drain_z", 32'(bus.out_z), 1);
            tick();
        end
        chk("ovf_drained", 32'(bus.out_valid), 0);

        // Reset with three products in flight discards all of them.
        bus.in_a     = 14'd2;
        bus.in_b     = 14'd3;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        bus.in_valid = 1'b0;
        rst_n        = 1'b0;
        tick();
        chk("mr_ready_in_rst", 32'(bus.in_ready), 0);
        chk("mr_out_valid", 32'(bus.out_valid), 0);
        rst_n = 1'b1;
        seen  = 0;
        for (int s = 0; s < 10; s++) begin
            tick();
            if (bus.out_valid) seen++;
        end
        chk("mr_no_results", 32'(seen), 0);
        chk("mr_ovf_cleared", 32'(ovf_err), 0);
        chk("mr_ready_back", 32'(bus.in_ready), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
